regfile_mp: RTL and testbench

- Parametrised successor to the single-cycle CPU register file.
- Provides NUM_RD asynchronous read ports, one synchronous write port, an x0 hardwired to zero, and an optional write-to-read bypass for pipelined cores.
- After reset, a hardware clear sequencer zeroes every entry, one per cycle, and signals completion on init_busy.
- Sits between decode (read addresses) and writeback (write port) in the single-cycle and future pipelined datapaths.

---
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a hardware clear sequencer.
//
// Purpose:
//   NUM_RD combinational read ports, one synchronous write port and an x0
//   entry that always reads as zero. An optional bypass forwards a write to
//   any read port addressing the same register in the same cycle. After
//   every reset a sequencer zeroes one entry per cycle. While it runs,
//   init_busy is high, all read ports return zero and writes are dropped.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset
//   regfile_wren     in   write enable
//   write_addr       in   [AW-1:0]          write address
//   regfile_data_in  in   [XLEN-1:0]        write data
//   read_addr        in   [NUM_RD*AW-1:0]   port k address = [k*AW +: AW]
//   regfile_data_out out  [NUM_RD*XLEN-1:0] port k data    = [k*XLEN +: XLEN]
//   init_busy        out  high while the clear sequence runs (registered)
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   regfile_wren,
  input  logic [AW-1:0]          write_addr,
  input  logic [XLEN-1:0]        regfile_data_in,
  input  logic [NUM_RD*AW-1:0]   read_addr,
  output logic [NUM_RD*XLEN-1:0] regfile_data_out,
  output logic                   init_busy
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   clr_ptr_reg, clr_ptr_next;
  logic            init_busy_reg, init_busy_next;

  logic [XLEN-1:0] mem [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // A user write is accepted only once the clear has finished, and never
  // to x0. The bypass uses the same qualifier so it can only forward data
  // that will actually be committed at the next edge.
  logic            wr_ok;
  assign wr_ok = !rst && (state_reg == READY) && regfile_wren && (write_addr != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      clr_ptr_reg   <= '0;
      init_busy_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      clr_ptr_reg   <= clr_ptr_next;
      init_busy_reg <= init_busy_next;
    end
  end

  // Next-state logic. The last clear write and the switch to READY happen
  // on the same edge, so init_busy is high for exactly NREGS cycles.
  always_comb begin
    state_next     = state_reg;
    clr_ptr_next   = clr_ptr_reg;
    init_busy_next = init_busy_reg;
    case (state_reg)
      CLEAR: begin
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == AW'(NREGS - 1)) begin
          state_next     = READY;
          init_busy_next = 1'b0;
        end
      end
      READY: begin
        init_busy_next = 1'b0;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // Single memory write port, shared by the clear sequencer and user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = regfile_data_in;
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_reg;
        mem_wdata = '0;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports. Forcing zero during reset/clear keeps the uninitialised
  // memory contents from ever reaching the outputs.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic          hit;
      assign ra  = read_addr[gi*AW +: AW];
      assign hit = (BYPASS != 0) && wr_ok && (write_addr == ra);
      assign regfile_data_out[gi*XLEN +: XLEN] =
          (rst || (state_reg == CLEAR) || (ra == '0)) ? '0 :
          hit ? regfile_data_in : mem[ra];
    end
  endgenerate

  assign init_busy = init_busy_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp.
// Two default-size instances (BYPASS=0 and BYPASS=1) share one stimulus
// stream and are compared against a behavioural model of the register
// file. A third instance (XLEN=64, NREGS=16, NUM_RD=4) covers the
// parameter sweep.
module tb_regfile_mp;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst, wren;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] out_nb, out_b;
  logic        busy_nb, busy_b;

  logic         rst2, wren2;
  logic [3:0]   waddr2;
  logic [63:0]  wdata2;
  logic [15:0]  raddr2;
  logic [255:0] out2;
  logic         busy2;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .regfile_wren(wren), .write_addr(waddr),
    .regfile_data_in(wdata), .read_addr(raddr),
    .regfile_data_out(out_nb), .init_busy(busy_nb));

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .regfile_wren(wren), .write_addr(waddr),
    .regfile_data_in(wdata), .read_addr(raddr),
    .regfile_data_out(out_b), .init_busy(busy_b));

  regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(4), .BYPASS(0)) dut_w (
    .clk(clk), .rst(rst2), .regfile_wren(wren2), .write_addr(waddr2),
    .regfile_data_in(wdata2), .read_addr(raddr2),
    .regfile_data_out(out2), .init_busy(busy2));

  // Reference model: register contents plus number of clear cycles left.
  logic [31:0] ref_mem [NR];
  int          clear_left;
  int          checks = 0;
  int          errors = 0;
  bit          do_chk;

  typedef struct {
    bit          w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a0, a1;
    logic [31:0] e0n, e1n, e0b, e1b;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst || clear_left > 0 || a == 5'd0) return 32'd0;
    if (byp && wren && waddr != 5'd0 && waddr == a) return wdata;
    return ref_mem[a];
  endfunction

  // Apply inputs, let them settle, compare both instances with the model.
  task automatic drive(input bit r, input bit w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
    rst = r; wren = w; waddr = wa; wdata = wd; raddr = {a1, a0};
    #1;
    if (do_chk) begin
      chk("busy_nb", 64'(busy_nb), 64'(clear_left > 0));
      chk("busy_b",  64'(busy_b),  64'(clear_left > 0));
      chk("nb_port0", 64'(out_nb[31:0]),  64'(exp_rd(a0, 1'b0)));
      chk("nb_port1", 64'(out_nb[63:32]), 64'(exp_rd(a1, 1'b0)));
      chk("b_port0",  64'(out_b[31:0]),   64'(exp_rd(a0, 1'b1)));
      chk("b_port1",  64'(out_b[63:32]),  64'(exp_rd(a1, 1'b1)));
    end
  endtask

  // Clock edge: update the model from the inputs the DUT just sampled.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      clear_left = NR;
      foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (wren && waddr != 5'd0) begin
      ref_mem[waddr] = wdata;
    end
    @(negedge clk);
  endtask

  // Idle until init_busy drops; returns how many cycles it stayed high.
  // Optionally issues a write of DEADBEEF to r5 during clear cycle 10.
  task automatic count_busy(input bit inject, output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!busy_nb) break;
      n++;
      if (inject && i == 10) drive(0, 1, 5'd5, 32'hDEADBEEF, 5'(i), 5'(i + 1));
      else                   drive(0, 0, 5'd0, 32'd0, 5'(i), 5'(i + 1));
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{0, 5'd0, 32'd0,         5'd1,  5'd2, 32'd101, 32'd102, 32'd101, 32'd102};
    tbl[1] = '{0, 5'd0, 32'd0,         5'd31, 5'd0, 32'd131, 32'd0,   32'd131, 32'd0};
    tbl[2] = '{1, 5'd7, 32'h12345678,  5'd7,  5'd7, 32'd107, 32'd107, 32'h12345678, 32'h12345678};
    tbl[3] = '{0, 5'd0, 32'd0,         5'd7,  5'd6, 32'h12345678, 32'd106, 32'h12345678, 32'd106};
    tbl[4] = '{1, 5'd0, 32'hAAAA5555,  5'd0,  5'd0, 32'd0,   32'd0,   32'd0,   32'd0};
    tbl[5] = '{0, 5'd5, 32'hDEADBEEF,  5'd5,  5'd5, 32'd105, 32'd105, 32'd105, 32'd105};
    tbl[6] = '{0, 5'd5, 32'hDEADBEEF,  5'd5,  5'd0, 32'd105, 32'd0,   32'd105, 32'd0};
    tbl[7] = '{0, 5'd0, 32'd0,         5'd5,  5'd0, 32'd105, 32'd0,   32'd105, 32'd0};

    clear_left = NR;
    foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    do_chk = 0;
    rst = 1; wren = 0; waddr = 0; wdata = 0; raddr = 0;
    rst2 = 1; wren2 = 0; waddr2 = 0; wdata2 = 0; raddr2 = 0;
    @(negedge clk);
    do_chk = 1;

    // Clear sequence with a dropped write to r5 at clear cycle 10.
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, 5'd3, 5'd4); advance(); end
    count_busy(1, n);
    chk("clear_len", 64'(n), 64'd32);
    for (int j = 0; j < NR; j += 2) begin
      drive(0, 0, 0, 0, 5'(j), 5'(j + 1));
      chk("post_clear_p0", 64'(out_nb[31:0]), 64'd0);
      chk("post_clear_p1", 64'(out_nb[63:32]), 64'd0);
      advance();
    end

    // Fill r_i = i+100, then read pairs.
    for (int i = 0; i < NR; i++) begin
      drive(0, 1, 5'(i), 32'(i + 100), 5'(i), 5'((i + 1) % NR));
      advance();
    end
    for (int j = 1; j <= 29; j += 2) begin
      drive(0, 0, 0, 0, 5'(j), 5'(j + 1));
      chk("pair_p0", 64'(out_nb[31:0]),  64'(j + 100));
      chk("pair_p1", 64'(out_nb[63:32]), 64'(j + 101));
      advance();
    end

    // Table vectors: bypass, x0 write, wren=0 guard.
    for (int k = 0; k < 8; k++) begin
      drive(0, tbl[k].w, tbl[k].wa, tbl[k].wd, tbl[k].a0, tbl[k].a1);
      $display("vec %0d: w=%0b wa=%0d wd=%h a=(%0d,%0d) nb=(%h,%h) b=(%h,%h)",
               k, tbl[k].w, tbl[k].wa, tbl[k].wd, tbl[k].a0, tbl[k].a1,
               out_nb[31:0], out_nb[63:32], out_b[31:0], out_b[63:32]);
      chk("tbl_nb0", 64'(out_nb[31:0]),  64'(tbl[k].e0n));
      chk("tbl_nb1", 64'(out_nb[63:32]), 64'(tbl[k].e1n));
      chk("tbl_b0",  64'(out_b[31:0]),   64'(tbl[k].e0b));
      chk("tbl_b1",  64'(out_b[63:32]),  64'(tbl[k].e1b));
      advance();
    end

    // Reset one cycle after fill: everything reads zero after the new clear.
    drive(1, 0, 0, 0, 5'd9, 5'd10); advance();
    count_busy(0, n);
    chk("reclear_len", 64'(n), 64'd32);
    for (int j = 0; j < NR; j += 2) begin
      drive(0, 0, 0, 0, 5'(j), 5'(j + 1));
      chk("reclear_p0", 64'(out_nb[31:0]), 64'd0);
      chk("reclear_p1", 64'(out_b[63:32]), 64'd0);
      advance();
    end

    // Reset at clear cycle 15 restarts a full clear.
    drive(1, 0, 0, 0, 0, 0); advance();
    for (int i = 0; i < 15; i++) begin drive(0, 1, 5'd3, 32'h55, 5'd3, 5'd3); advance(); end
    drive(1, 0, 0, 0, 0, 0); advance();
    count_busy(0, n);
    chk("restart_len", 64'(n), 64'd32);

    // Randomised traffic against the model, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom);
      drive(($urandom % 64) == 0, 1'($urandom), wa, $urandom,
            (($urandom % 3) == 0) ? wa : 5'($urandom), 5'($urandom));
      advance();
    end

    // Parameter sweep instance.
    @(negedge clk); @(negedge clk);
    rst2 = 0;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!busy2) break;
      n++;
      raddr2 = {4{4'(i)}};
      wren2 = 1; waddr2 = 4'd15; wdata2 = 64'h1;
      #1;
      chk("w_clear_out", out2, 256'd0);
      @(negedge clk);
    end
    chk("w_clear_len", 64'(n), 64'd16);
    wren2 = 1; waddr2 = 4'd15; wdata2 = 64'hFFFF_0000_0000_000F; raddr2 = {4{4'd15}};
    #1;
    chk("w_rbw", out2[63:0], 64'd0);
    @(negedge clk);
    wren2 = 0; #1;
    for (int k = 0; k < 4; k++) chk("w_port", out2[k*64 +: 64], 64'hFFFF_0000_0000_000F);
    raddr2 = {4'd15, 4'd15, 4'd15, 4'd0}; #1;
    chk("w_x0", out2[63:0], 64'd0);
    chk("w_p3", out2[255:192], 64'hFFFF_0000_0000_000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
